// File: rtl/mfm_read_frontend_pkg.sv
// mfm_read_frontend_pkg: shared interval bin, state and phase codes plus the interval classifier
package mfm_read_frontend_pkg;
  typedef enum logic [2:0] {IV_SHORT, IV_1T, IV_15T, IV_2T, IV_LONG} iv_t;
  typedef enum logic {ST_HUNT, ST_DATA} st_t;
  typedef enum logic {PH_C, PH_D} ph_t;
  function automatic iv_t classify(input int i, input int t);
    return i < 3 * t / 4 ? IV_SHORT :
           i < 5 * t / 4 ? IV_1T :
           i < 7 * t / 4 ? IV_15T :
           i <= 9 * t / 4 ? IV_2T : IV_LONG;
  endfunction
endpackage

// File: rtl/mfm_interval_timer.sv
// mfm_interval_timer: synchronise mfm_in, strobe each edge and bin the interval since the previous one
module mfm_interval_timer
  import mfm_read_frontend_pkg::*;
#(
  parameter int CELL_CLKS   = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic mfm_in,
  output logic edge_stb,
  output logic long_stb,
  output iv_t  bin
);
  localparam int L_MAX = 9 * CELL_CLKS / 4;
  localparam int CW = $clog2(L_MAX + 2);
  logic [SYNC_STAGES-1:0] sync;
  logic prev;
  logic [CW-1:0] cnt;
  logic det;
  assign det = sync[SYNC_STAGES-1] ^ prev;
  // counter starts saturated so the first edge after reset reads as LONG; LONG strobes once on reaching L_MAX+1
  always_ff @(posedge clk) begin
    if (rst) begin
      sync     <= '0;
      prev     <= 1'b0;
      cnt      <= CW'(L_MAX + 1);
      edge_stb <= 1'b0;
      long_stb <= 1'b0;
      bin      <= IV_SHORT;
    end else begin
      sync     <= {sync[SYNC_STAGES-2:0], mfm_in};
      prev     <= sync[SYNC_STAGES-1];
      edge_stb <= det;
      long_stb <= !det && cnt == CW'(L_MAX);
      bin      <= det ? classify(int'(cnt), CELL_CLKS) : IV_LONG;
      cnt      <= det ? CW'(1) : cnt == CW'(L_MAX + 1) ? cnt : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/mfm_read_frontend.sv
// mfm_read_frontend: lock to MFM preamble/sync, decode interval bins to bits and deserialise words
module mfm_read_frontend
  import mfm_read_frontend_pkg::*;
#(
  parameter int CELL_CLKS    = 24,
  parameter int WORD_W       = 16,
  parameter int PREAMBLE_MIN = 16,
  parameter bit LSB_FIRST    = 1,
  parameter int SYNC_STAGES  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mfm_in,
  input  logic              resync,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              locked,
  output logic              code_err
);
  generate
    if (CELL_CLKS < 8) begin : g_cell_chk
      $error("CELL_CLKS must be >= 8 so the two-bit queue cannot overflow");
    end
  endgenerate
  localparam int PW = $clog2(PREAMBLE_MIN + 1);
  localparam int BW = $clog2(WORD_W);
  logic edge_stb, long_stb;
  iv_t bin;
  st_t state;
  ph_t phase, nph;
  logic [PW-1:0] pcount;
  logic pend, pend_bit;
  logic [BW-1:0] bcnt;
  logic [WORD_W-1:0] sreg, nxt_word;
  logic ev, err, two, b0, b1, sync_hit, word_done;
  mfm_interval_timer #(.CELL_CLKS(CELL_CLKS), .SYNC_STAGES(SYNC_STAGES)) u_timer (
    .clk(clk), .rst(rst), .mfm_in(mfm_in), .edge_stb(edge_stb), .long_stb(long_stb), .bin(bin)
  );
  // bin-to-bits decode for the current phase; phase D may yield two bits from one interval
  always_comb begin
    ev        = edge_stb | long_stb;
    err       = phase == PH_C ? !(bin == IV_1T || bin == IV_15T) : (bin == IV_SHORT || bin == IV_LONG);
    two       = phase == PH_D && bin != IV_1T;
    b0        = phase == PH_C ? bin == IV_15T : bin == IV_1T;
    b1        = bin == IV_2T;
    nph       = bin == IV_1T ? phase : phase == PH_C ? PH_D : bin == IV_15T ? PH_C : PH_D;
    sync_hit  = bin == IV_15T && pcount >= PW'(PREAMBLE_MIN);
    nxt_word  = LSB_FIRST ? {bit_out, sreg[WORD_W-1:1]} : {sreg[WORD_W-2:0], bit_out};
    word_done = bit_valid && bcnt == BW'(WORD_W - 1);
  end
  // lock FSM, bit queue and deserialiser; a flush keeps word_out at the last complete word
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_HUNT;
      phase      <= PH_C;
      pcount     <= '0;
      pend       <= 1'b0;
      pend_bit   <= 1'b0;
      bcnt       <= '0;
      sreg       <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      locked     <= 1'b0;
      code_err   <= 1'b0;
    end else if (resync || (ev && state == ST_DATA && err)) begin
      state      <= ST_HUNT;
      locked     <= 1'b0;
      code_err   <= !resync;
      pcount     <= '0;
      pend       <= 1'b0;
      bit_valid  <= 1'b0;
      bcnt       <= '0;
      word_valid <= 1'b0;
    end else begin
      code_err   <= 1'b0;
      word_valid <= word_done;
      if (bit_valid) begin
        sreg <= nxt_word;
        bcnt <= word_done ? '0 : bcnt + 1'b1;
        if (word_done) word_out <= nxt_word;
      end
      if (state == ST_HUNT) begin
        bit_valid <= 1'b0;
        pend      <= 1'b0;
        if (ev) pcount <= bin != IV_1T ? '0 : pcount == PW'(PREAMBLE_MIN) ? pcount : pcount + 1'b1;
        if (ev && sync_hit) begin
          state  <= ST_DATA;
          locked <= 1'b1;
          phase  <= PH_D;
          pcount <= '0;
          bcnt   <= '0;
        end
      end else if (ev) begin
        bit_out   <= b0;
        bit_valid <= 1'b1;
        pend      <= two;
        pend_bit  <= b1;
        phase     <= nph;
      end else begin
        bit_valid <= pend;
        bit_out   <= pend ? pend_bit : bit_out;
        pend      <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_mfm_read_frontend.sv
// tb_mfm_read_frontend: directed MFM waveforms with hand-derived bits, words, lock and error outcomes
module tb_mfm_read_frontend;
  logic clk = 1'b0, rst = 1'b1, mfm_in = 1'b0, resync = 1'b0;
  logic bit_out, bit_valid, word_valid, locked, code_err;
  logic [15:0] word_out;
  int n_cmp = 0, n_bad = 0;
  int nbv = 0, nwv = 0, nce = 0, cyc = 0;
  logic bits_q[$];
  int cyc_q[$];
  logic enc_prev = 1'b1;
  int enc_dist = 0;
  int b, w, e;
  string tag;
  int bn[7] = '{17, 18, 29, 30, 41, 42, 54};
  int bnb[7] = '{0, 1, 1, 2, 2, 2, 2};
  int berr[7] = '{1, 0, 0, 0, 0, 0, 0};
  logic [1:0] bbits[7] = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};

  always #5 clk = ~clk;

  mfm_read_frontend #(.CELL_CLKS(24), .WORD_W(16), .PREAMBLE_MIN(16), .LSB_FIRST(1), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .mfm_in(mfm_in), .resync(resync), .bit_out(bit_out), .bit_valid(bit_valid),
    .word_out(word_out), .word_valid(word_valid), .locked(locked), .code_err(code_err)
  );

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (bit_valid) begin
        bits_q.push_back(bit_out);
        cyc_q.push_back(cyc);
        nbv++;
      end
      if (word_valid) nwv++;
      if (code_err) nce++;
    end
  end

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", t, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic toggle_after(input int n);
    repeat (n) @(posedge clk);
    #1 mfm_in = ~mfm_in;
  endtask

  // edges-1 intervals of 1T after a leading edge, then the 1.5T sync
  task automatic preamble(input int edges);
    for (int i = 0; i < edges; i++) toggle_after(24);
    toggle_after(36);
    enc_prev = 1'b1;
    enc_dist = 0;
  endtask

  // MFM encode at half-cell resolution (12 clks), bit i = v[i]
  task automatic send_bits(input logic [31:0] v, input int n);
    logic bb, cc;
    for (int i = 0; i < n; i++) begin
      bb = v[i];
      cc = !(enc_prev | bb);
      enc_dist++;
      if (cc) begin
        toggle_after(enc_dist * 12);
        enc_dist = 0;
      end
      enc_dist++;
      if (bb) begin
        toggle_after(enc_dist * 12);
        enc_dist = 0;
      end
      enc_prev = bb;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_bit_valid", 32'(bit_valid), 0);
    check("rst_word_valid", 32'(word_valid), 0);
    check("rst_word_out", 32'(word_out), 0);
    check("rst_locked", 32'(locked), 0);
    check("rst_code_err", 32'(code_err), 0);
    @(posedge clk);
    #1 rst = 1'b0;
    idle(5);

    b = nbv; w = nwv; e = nce;
    preamble(20);
    send_bits(32'h0000A5C3, 16);
    idle(10);
    check("word_locked", 32'(locked), 1);
    check("word_bits", nbv - b, 16);
    check("word_first_bit", 32'(bits_q[b]), 1);
    check("word_valid_cnt", nwv - w, 1);
    check("word_value", 32'(word_out), 32'hA5C3);
    check("word_no_err", nce - e, 0);
    idle(70);
    check("long_err", nce - e, 1);
    check("long_unlocked", 32'(locked), 0);

    preamble(20);
    b = nbv; w = nwv; e = nce;
    send_bits(32'h0, 2);
    toggle_after(48);
    idle(10);
    check("c2t_bits", nbv - b, 2);
    check("c2t_err_pulse", nce - e, 1);
    check("c2t_unlocked", 32'(locked), 0);
    check("c2t_no_word", nwv - w, 0);
    check("c2t_word_held", 32'(word_out), 32'hA5C3);
    idle(70);

    for (int k = 0; k < 7; k++) begin
      preamble(20);
      b = nbv; e = nce;
      toggle_after(bn[k]);
      idle(10);
      tag = $sformatf("bin%0d", bn[k]);
      check({tag, "_bits"}, nbv - b, bnb[k]);
      check({tag, "_err"}, nce - e, berr[k]);
      if (bnb[k] > 0 && nbv > b) check({tag, "_b0"}, 32'(bits_q[b]), 32'(bbits[k][0]));
      if (bnb[k] == 2 && nbv > b + 1) check({tag, "_b1"}, 32'(bits_q[b+1]), 32'(bbits[k][1]));
      idle(70);
    end

    b = nbv;
    preamble(16);
    idle(10);
    check("short_pre_unlocked", 32'(locked), 0);
    check("short_pre_no_bits", nbv - b, 0);
    idle(70);

    preamble(20);
    b = nbv; e = nce;
    send_bits(32'h4D, 7);
    toggle_after(24);
    repeat (3) @(posedge clk);
    #1 resync = 1'b1;
    @(posedge clk);
    #1 resync = 1'b0;
    idle(5);
    check("resync_bits", nbv - b, 7);
    check("resync_no_err", nce - e, 0);
    check("resync_unlocked", 32'(locked), 0);
    preamble(20);
    w = nwv;
    send_bits(32'h00009E37, 16);
    idle(10);
    check("relock_words", nwv - w, 1);
    check("relock_value", 32'(word_out), 32'h9E37);
    idle(70);

    preamble(20);
    b = nbv;
    toggle_after(36);
    idle(6);
    check("d15_bits", nbv - b, 2);
    if (nbv >= b + 2) begin
      check("d15_b0", 32'(bits_q[b]), 0);
      check("d15_b1", 32'(bits_q[b+1]), 0);
      check("d15_adjacent", cyc_q[b+1] - cyc_q[b], 1);
    end
    enc_prev = 1'b0;
    enc_dist = 1;
    send_bits(32'h5, 3);
    idle(4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_bit_valid", 32'(bit_valid), 0);
    check("mid_rst_bit_out", 32'(bit_out), 0);
    check("mid_rst_word_valid", 32'(word_valid), 0);
    check("mid_rst_word_out", 32'(word_out), 0);
    check("mid_rst_locked", 32'(locked), 0);
    check("mid_rst_code_err", 32'(code_err), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
